// File: rtl/lsu.sv
// Multi-cycle load/store unit: aligns and issues one data-memory request per
// load/store, extends load data, and tells the decoder when the access is done.
module lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_update,
    input  logic              data_ram_en,
    input  logic              data_ram_wen,
    input  logic [7:0]        wmask,
    input  logic [6:0]        l_choose,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_finish,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [7:0]          wmask_q;
    logic [6:0]          lch_q;
    logic                store_q;
    logic                mem_op;
    logic                accept;
    logic                aligned;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_val;

    assign mem_op = inst_update & (data_ram_en | data_ram_wen);
    assign accept = mem_op && (state == IDLE || state == DONE);

    // Access size comes from whichever control is active: l_choose for loads, wmask for stores.
    always_comb begin
        aligned = 1'b1;
        if (l_choose[0] || wmask == 8'hFF)
            aligned = (addr[2:0] == 3'b000);
        else if (l_choose[1] || l_choose[2] || wmask == 8'h0F)
            aligned = (addr[1:0] == 2'b00);
        else if (l_choose[3] || l_choose[4] || wmask == 8'h03)
            aligned = ~addr[0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (mem_op) state_nx = aligned ? REQ : DONE;
            REQ:  if (mem_req_ready) state_nx = WAIT;
            WAIT: if (mem_resp_valid) state_nx = DONE;
            DONE: begin
                if (mem_op)           state_nx = aligned ? REQ : DONE;
                else if (inst_update) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            lch_q    <= '0;
            store_q  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q   <= addr;
                wdata_q  <= wdata;
                wmask_q  <= wmask;
                lch_q    <= l_choose;
                store_q  <= data_ram_wen;
                misalign <= ~aligned;
            end
        end
    end

    assign shifted = mem_resp_data >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_val = '0;
        if (lch_q[0])      load_val = shifted;
        else if (lch_q[1]) load_val = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
        else if (lch_q[2]) load_val = {{(DATA_W-32){1'b0}}, shifted[31:0]};
        else if (lch_q[3]) load_val = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        else if (lch_q[4]) load_val = {{(DATA_W-16){1'b0}}, shifted[15:0]};
        else if (lch_q[5]) load_val = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
        else if (lch_q[6]) load_val = {{(DATA_W-8){1'b0}}, shifted[7:0]};
    end

    // Only a response in WAIT counts; strays in other states are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata_ext <= '0;
        else if (state == WAIT && mem_resp_valid && !store_q)
            rdata_ext <= load_val;
    end

    assign mem_req_valid = (state == REQ);
    assign mem_finish    = (state == IDLE || state == DONE) && !accept;
    assign mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_req_wen   = store_q;
    assign mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
    assign mem_req_wmask = wmask_q << addr_q[2:0];

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized loads/stores
// against a transaction-level reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_update = 1'b0;
    logic        data_ram_en = 1'b0;
    logic        data_ram_wen = 1'b0;
    logic [7:0]  wmask = '0;
    logic [6:0]  l_choose = '0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        mem_finish;
    logic [63:0] rdata_ext;
    logic        misalign;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_rdata = '0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .inst_update(inst_update),
        .data_ram_en(data_ram_en), .data_ram_wen(data_ram_wen),
        .wmask(wmask), .l_choose(l_choose), .addr(addr), .wdata(wdata),
        .mem_finish(mem_finish), .rdata_ext(rdata_ext), .misalign(misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int acc_size(input bit st, input logic [6:0] lch, input logic [7:0] wm);
        if (st) begin
            if (wm == 8'hFF) return 8;
            if (wm == 8'h0F) return 4;
            if (wm == 8'h03) return 2;
            return 1;
        end
        if (lch[0]) return 8;
        if (lch[1] || lch[2]) return 4;
        if (lch[3] || lch[4]) return 2;
        return 1;
    endfunction

    // Load result: keep the low n bytes, then optionally sign-fill the rest.
    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [6:0] lch);
        int          n;
        bit          sgn;
        logic [63:0] mask, v;
        if (lch == 7'd0) return 64'd0;
        n    = acc_size(1'b0, lch, 8'h00);
        sgn  = lch[1] | lch[3] | lch[5];
        mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v    = raw & mask;
        if (sgn && n < 8 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_op(input bit st, input logic [6:0] lch, input logic [7:0] wm,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                         input int rdly, input int sdly);
        int          n;
        bit          ok;
        int          off;
        logic [15:0] wm_wide;
        logic [63:0] e_addr, e_wdata;
        logic [7:0]  e_wmask;
        n       = acc_size(st, lch, wm);
        ok      = (a % n) == 0;
        off     = int'(a % 8);
        e_addr  = a - (a % 8);
        e_wdata = wd << (8 * off);
        wm_wide = {8'h00, wm} << off;
        e_wmask = wm_wide[7:0];

        @(negedge clk);
        inst_update = 1'b1; data_ram_en = !st; data_ram_wen = st;
        l_choose = lch; wmask = wm; addr = a; wdata = wd;
        #1 check("finish_low_on_accept", {63'd0, mem_finish}, 64'd0);

        @(negedge clk);
        inst_update = 1'b0; data_ram_en = 1'b0; data_ram_wen = 1'b0;
        addr = rnd64(); wdata = rnd64(); wmask = 8'($urandom); l_choose = 7'($urandom);
        if (!ok) begin
            #1;
            check("misalign_flag", {63'd0, misalign}, 64'd1);
            check("misalign_no_req", {63'd0, mem_req_valid}, 64'd0);
            check("misalign_finish", {63'd0, mem_finish}, 64'd1);
            check("misalign_rdata_hold", rdata_ext, exp_rdata);
            return;
        end

        for (int i = 0; i <= rdly; i++) begin
            mem_req_ready  = (i == rdly);
            mem_resp_valid = (i != rdly) && ($urandom_range(0, 1) == 1);
            mem_resp_data  = rnd64();
            #1;
            check("req_valid", {63'd0, mem_req_valid}, 64'd1);
            check("req_addr", mem_req_addr, e_addr);
            check("req_wen", {63'd0, mem_req_wen}, {63'd0, st});
            if (st) begin
                check("req_wdata", mem_req_wdata, e_wdata);
                check("req_wmask", {56'd0, mem_req_wmask}, {56'd0, e_wmask});
            end
            check("req_finish_low", {63'd0, mem_finish}, 64'd0);
            check("req_misalign_clear", {63'd0, misalign}, 64'd0);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;

        for (int j = 0; j <= sdly; j++) begin
            mem_resp_valid = (j == sdly);
            mem_resp_data  = (j == sdly) ? rd : rnd64();
            #1;
            check("wait_single_handshake", {63'd0, mem_req_valid}, 64'd0);
            check("wait_finish_low", {63'd0, mem_finish}, 64'd0);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = rnd64();
        if (!st) exp_rdata = extend(rd >> (8 * off), lch);
        #1;
        check("done_finish", {63'd0, mem_finish}, 64'd1);
        check("done_rdata", rdata_ext, exp_rdata);
    endtask

    // A non-memory cycle, optionally with an instruction pulse and a stray response.
    task automatic idle_cycle(input bit upd, input bit stray);
        @(negedge clk);
        inst_update    = upd;
        mem_resp_valid = stray;
        mem_resp_data  = rnd64();
        #1;
        check("idle_finish", {63'd0, mem_finish}, 64'd1);
        check("idle_no_req", {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk);
        #1;
        inst_update    = 1'b0;
        mem_resp_valid = 1'b0;
        check("idle_rdata_hold", rdata_ext, exp_rdata);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_finish", {63'd0, mem_finish}, 64'd1);
        check("rst_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_wen", {63'd0, mem_req_wen}, 64'd0);
        check("rst_misalign", {63'd0, misalign}, 64'd0);
        check("rst_rdata", rdata_ext, 64'd0);
        check("rst_addr", mem_req_addr, 64'd0);
        check("rst_wdata", mem_req_wdata, 64'd0);
        check("rst_wmask", {56'd0, mem_req_wmask}, 64'd0);
        rst_n = 1'b1;

        do_op(1'b0, 7'b0000010, 8'h00, 64'h8000_0004, 64'd0, 64'hFFFF_8000_0000_0000, 0, 0);
        do_op(1'b0, 7'b1000000, 8'h00, 64'h8000_0007, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 0);
        do_op(1'b0, 7'b0100000, 8'h00, 64'h8000_0007, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 0);
        do_op(1'b1, 7'b0000000, 8'h03, 64'h8000_0006, 64'h0000_0000_0000_BEEF, rnd64(), 1, 1);
        do_op(1'b0, 7'b0000010, 8'h00, 64'h8000_0002, 64'd0, rnd64(), 0, 0);
        do_op(1'b0, 7'b0000001, 8'h00, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 2);
        do_op(1'b0, 7'b0000000, 8'h00, 64'h8000_0003, 64'd0, rnd64(), 0, 1);
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b0, 1'b1);

        for (int k = 0; k < 200; k++) begin
            int          sel;
            bit          st;
            logic [6:0]  lch;
            logic [7:0]  wm;
            sel = $urandom_range(0, 10);
            st  = (sel >= 7);
            if (st) begin
                lch = 7'd0;
                case (sel)
                    7:       wm = 8'h01;
                    8:       wm = 8'h03;
                    9:       wm = 8'h0F;
                    default: wm = 8'hFF;
                endcase
            end else begin
                lch = 7'(1 << sel);
                wm  = 8'h00;
            end
            do_op(st, lch, wm, 64'h8000_0000 + 64'($urandom_range(0, 63)), rnd64(), rnd64(),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                idle_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Reset while waiting for a load response.
        @(negedge clk);
        inst_update = 1'b1; data_ram_en = 1'b1; l_choose = 7'b0000001; addr = 64'h8000_0008;
        @(negedge clk);
        inst_update = 1'b0; data_ram_en = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        exp_rdata = 64'd0;
        #1;
        check("midrst_finish", {63'd0, mem_finish}, 64'd1);
        check("midrst_valid", {63'd0, mem_req_valid}, 64'd0);
        check("midrst_rdata", rdata_ext, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("late_resp_ignored", rdata_ext, 64'd0);
        check("late_resp_finish", {63'd0, mem_finish}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
